decode_mc: RTL and testbench

Parametrised multicycle control unit for the ARM core, replacing the decode-plus-mainfsm pair. It holds the instruction-sequencing FSM, an extended ALU decoder (EOR, CMP and MOV in addition to ADD, SUB, AND and ORR), and an iterative-multiply stall counter. It sits between the instruction register and the datapath, and produces every datapath enable and select.

---
 rtl/decode_mc_pkg.sv | 49 ++++
 rtl/alu_dec_ext.sv | 51 +++++
 rtl/decode_mc.sv | 204 ++++++++++++++++++++
 tb/tb_decode_mc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_mc_pkg.sv
// ============================================================================
// Module   : decode_mc_pkg
// Brief    : Shared state encoding, ALU codes and instruction-field constants
//            for the multicycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_MULEXEC = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] MUL_I74 = 4'b1001;

endpackage

`default_nettype wire

// File: rtl/alu_dec_ext.sv
// ============================================================================
// Module   : alu_dec_ext
// Brief    : Combinational extended ALU decoder (ADD/SUB/AND/ORR/EOR/CMP/MOV).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_dec_ext
  import decode_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 i_aluop,
  input  logic [4:0]           i_funct,
  output logic [ALUCTRL_W-1:0] o_alucontrol,
  output logic [1:0]           o_flagw,
  output logic                 o_nowrite,
  output logic                 o_illegal_cmd
);

  logic [2:0]           w_code;
  logic                 w_cv;
  logic [ALUCTRL_W-1:0] w_code_ext;

  always_comb begin
    w_code        = ALU_ADD;
    w_cv          = 1'b0;
    o_nowrite     = 1'b0;
    o_illegal_cmd = 1'b0;
    case (i_funct[4:1])
      CMD_ADD: begin w_code = ALU_ADD; w_cv = 1'b1; end
      CMD_SUB: begin w_code = ALU_SUB; w_cv = 1'b1; end
      CMD_AND: w_code = ALU_AND;
      CMD_ORR: w_code = ALU_ORR;
      CMD_EOR: w_code = ALU_EOR;
      CMD_CMP: begin w_code = ALU_SUB; w_cv = 1'b1; o_nowrite = 1'b1; end
      CMD_MOV: w_code = ALU_MOV;
      default: o_illegal_cmd = 1'b1;
    endcase
  end

  always_comb begin
    w_code_ext      = '0;
    w_code_ext[2:0] = w_code;
    o_alucontrol    = i_aluop ? w_code_ext : '0;
    o_flagw         = i_aluop ? {i_funct[0], i_funct[0] & w_cv} : 2'b00;
  end

endmodule

`default_nettype wire

// File: rtl/decode_mc.sv
// ============================================================================
// Module   : decode_mc
// Brief    : Multicycle ARM control unit: sequencing FSM, extended ALU decode
//            and iterative-multiply stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_mc
  import decode_mc_pkg::*;
#(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Instr74,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulEn,
  output logic                 Illegal,
  output logic [3:0]           State
);

  localparam int                CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  state_t               w_st_eff;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_nowrite;
  logic                 r_mul;

  logic                 w_mul_pat;
  logic                 w_is_mul;
  logic                 w_dp_legal;
  logic                 w_dec_illegal;
  logic                 w_aluop;
  logic                 w_branch;
  logic                 w_irwrite;
  logic                 w_nextpc;
  logic                 w_regw;
  logic                 w_memw;
  logic                 w_mulen;
  logic [ALUCTRL_W-1:0] w_dec_alucontrol;
  logic [ALUCTRL_W-1:0] w_mul_code;
  logic [1:0]           w_dec_flagw;
  logic                 w_dec_nowrite;
  logic                 w_dec_illegal_cmd;

  alu_dec_ext #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_dec (
    .i_aluop       (w_aluop),
    .i_funct       (Funct[4:0]),
    .o_alucontrol  (w_dec_alucontrol),
    .o_flagw       (w_dec_flagw),
    .o_nowrite     (w_dec_nowrite),
    .o_illegal_cmd (w_dec_illegal_cmd)
  );

  // The MUL encoding overlaps AND, so it is excluded from normal data processing.
  assign w_mul_pat  = (Op == OP_DP) && (Funct[5:4] == 2'b00) && (Instr74 == MUL_I74);
  assign w_is_mul   = w_mul_pat && (ENABLE_MUL != 0);
  assign w_dp_legal = (Op == OP_DP) && !w_mul_pat && !w_dec_illegal_cmd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_nowrite <= 1'b0;
      r_mul     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_MULEXEC) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == S_MULEXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == S_FETCH) begin
        r_nowrite <= 1'b0;
        r_mul     <= 1'b0;
      end else if (r_state == S_DECODE) begin
        r_nowrite <= w_dec_nowrite & w_dp_legal;
        r_mul     <= w_is_mul;
      end
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_dec_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (Op == OP_MEM)      w_next = S_MEMADR;
        else if (Op == OP_BR)  w_next = S_BRANCH;
        else if (w_is_mul)     w_next = S_MULEXEC;
        else if (w_dp_legal)   w_next = Funct[5] ? S_EXECI : S_EXECR;
        else                   w_dec_illegal = 1'b1;
      end
      S_MEMADR:  w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:   w_next = S_ALUWB;
      S_MULEXEC: w_next = (r_cnt == '0) ? S_ALUWB : S_MULEXEC;
      default:   w_next = S_FETCH;
    endcase
  end

  // While reset is held the selects behave as in FETCH and enables are masked.
  always_comb begin
    w_st_eff  = reset ? r_state : S_FETCH;
    w_irwrite = 1'b0;
    w_nextpc  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_mulen   = 1'b0;
    w_branch  = 1'b0;
    w_aluop   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (w_st_eff)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_nextpc  = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR: w_aluop = 1'b1;
      S_EXECI: begin
        w_aluop = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_ALUWB: w_regw = !r_nowrite;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      S_MULEXEC: w_mulen = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_mul_code      = '0;
    w_mul_code[2:0] = ALU_MUL;
    if (w_st_eff == S_MULEXEC) begin
      ALUControl = w_mul_code;
      FlagW      = {Funct[0], 1'b0};
    end else begin
      ALUControl = w_dec_alucontrol;
      FlagW      = w_dec_flagw;
    end
    ImmSrc  = Op;
    RegSrc  = {Op == OP_MEM, Op == OP_BR};
    IRWrite = reset & w_irwrite;
    NextPC  = reset & w_nextpc;
    RegW    = reset & w_regw;
    MemW    = reset & w_memw;
    MulEn   = reset & w_mulen;
    PCS     = reset & (((Rd == 4'hF) & w_regw & !r_mul) | w_branch);
    Illegal = reset & w_dec_illegal;
    State   = r_state;
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_mc.sv
// ============================================================================
// Module   : tb_decode_mc
// Brief    : Scoreboard bench for decode_mc, two parameterisations driven with
//            directed and random instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_mc;
  import decode_mc_pkg::*;

  localparam int DUT0_MC = 4;
  localparam bit DUT0_EN = 1'b1;
  localparam int DUT1_MC = 1;
  localparam bit DUT1_EN = 1'b0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, npc, regw, memw, adr, pcs, mulen, ill;
    logic [1:0] rs, sa, sb, imm, rsrc;
    logic [3:0] ac;
    logic [1:0] fw;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [1:0] op_i  [2];
  logic [5:0] fn_i  [2];
  logic [3:0] rd_i  [2];
  logic [3:0] i74_i [2];

  logic [1:0] fw0, fw1, rs0, rs1, sa0, sa1, sb0, sb1, imm0, imm1, rsrc0, rsrc1;
  logic       pcs0, pcs1, npc0, npc1, regw0, regw1, memw0, memw1, irw0, irw1;
  logic       adr0, adr1, mul0, mul1, ill0, ill1;
  logic [2:0] ac0;
  logic [3:0] ac1, st0, st1;
  rec_t       act0, act1;

  decode_mc #(.ALUCTRL_W(3), .MUL_CYCLES(DUT0_MC), .ENABLE_MUL(1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .Op(op_i[0]), .Funct(fn_i[0]), .Rd(rd_i[0]),
    .Instr74(i74_i[0]), .FlagW(fw0), .PCS(pcs0), .NextPC(npc0), .RegW(regw0),
    .MemW(memw0), .IRWrite(irw0), .AdrSrc(adr0), .ResultSrc(rs0), .ALUSrcA(sa0),
    .ALUSrcB(sb0), .ImmSrc(imm0), .RegSrc(rsrc0), .ALUControl(ac0), .MulEn(mul0),
    .Illegal(ill0), .State(st0)
  );

  decode_mc #(.ALUCTRL_W(4), .MUL_CYCLES(DUT1_MC), .ENABLE_MUL(0)) dut1 (
    .clk(clk), .reset(rst_n[1]), .Op(op_i[1]), .Funct(fn_i[1]), .Rd(rd_i[1]),
    .Instr74(i74_i[1]), .FlagW(fw1), .PCS(pcs1), .NextPC(npc1), .RegW(regw1),
    .MemW(memw1), .IRWrite(irw1), .AdrSrc(adr1), .ResultSrc(rs1), .ALUSrcA(sa1),
    .ALUSrcB(sb1), .ImmSrc(imm1), .RegSrc(rsrc1), .ALUControl(ac1), .MulEn(mul1),
    .Illegal(ill1), .State(st1)
  );

  assign act0 = {st0, irw0, npc0, regw0, memw0, adr0, pcs0, mul0, ill0,
                 rs0, sa0, sb0, imm0, rsrc0, {1'b0, ac0}, fw0};
  assign act1 = {st1, irw1, npc1, regw1, memw1, adr1, pcs1, mul1, ill1,
                 rs1, sa1, sb1, imm1, rsrc1, ac1, fw1};

  rec_t q0[$], q1[$];
  int   t0[$], t1[$];
  int   total = 0;
  int   bad   = 0;
  int   inum [2];

  // {sets-carry/overflow, ALU code} for each supported command
  function automatic logic [4:0] alu_ref(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {1'b1, 4'd0};
      4'b0010: return {1'b1, 4'd1};
      4'b0000: return {1'b0, 4'd2};
      4'b1100: return {1'b0, 4'd3};
      4'b0001: return {1'b0, 4'd4};
      4'b1010: return {1'b1, 4'd1};
      4'b1101: return {1'b0, 4'd6};
      default: return 5'h1F;
    endcase
  endfunction

  function automatic bit cmd_legal(input logic [3:0] cmd);
    logic [3:0] legal_cmds [7] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1101};
    foreach (legal_cmds[i]) if (legal_cmds[i] == cmd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rec_t model_out(input state_t st, input logic [1:0] op, input logic [5:0] fn,
                                     input logic [3:0] rd, input bit nw, input bit ismul,
                                     input bit ill, input bit in_rst);
    rec_t r;
    logic [4:0] a;
    r      = '0;
    r.st   = st;
    r.imm  = op;
    r.rsrc = {op == 2'b01, op == 2'b10};
    if (in_rst) begin
      r.sa = 2'b01; r.sb = 2'b10; r.rs = 2'b10;
      return r;
    end
    case (st)
      S_FETCH:   begin r.irw = 1; r.npc = 1; r.sa = 2'b01; r.sb = 2'b10; r.rs = 2'b10; end
      S_DECODE:  begin r.sa = 2'b01; r.sb = 2'b10; r.rs = 2'b10; r.ill = ill; end
      S_MEMADR:  r.sb = 2'b01;
      S_MEMRD:   r.adr = 1;
      S_MEMWB:   begin r.rs = 2'b01; r.regw = 1; r.pcs = (rd == 4'hF); end
      S_MEMWR:   begin r.adr = 1; r.memw = 1; end
      S_EXECR, S_EXECI: begin
        a    = alu_ref(fn[4:1]);
        r.sb = (st == S_EXECI) ? 2'b01 : 2'b00;
        r.ac = a[3:0];
        r.fw = {fn[0], fn[0] & a[4]};
      end
      S_ALUWB:   begin r.regw = !nw; r.pcs = !nw && !ismul && (rd == 4'hF); end
      S_BRANCH:  begin r.sb = 2'b01; r.rs = 2'b10; r.pcs = 1; end
      S_MULEXEC: begin r.mulen = 1; r.ac = 4'd5; r.fw = {fn[0], 1'b0}; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic push(input int k, input rec_t r, input int t);
    if (k == 0) begin q0.push_back(r); t0.push_back(t); end
    else        begin q1.push_back(r); t1.push_back(t); end
  endtask

  // Called one step after the rising edge that starts the instruction's FETCH.
  task automatic issue(input int k, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] d, input logic [3:0] i7, input int abort_at);
    state_t seq[$];
    bit mulpat, en, ill, nw, ismul;
    int mc, ab, tag;
    en     = (k == 0) ? DUT0_EN : DUT1_EN;
    mc     = (k == 0) ? DUT0_MC : DUT1_MC;
    mulpat = (o == 2'b00) && (f[5:4] == 2'b00) && (i7 == 4'b1001);
    ill = 0; nw = 0; ismul = 0;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    if (o == 2'b01) begin
      seq.push_back(S_MEMADR);
      if (f[0]) begin seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
      else seq.push_back(S_MEMWR);
    end else if (o == 2'b10) begin
      seq.push_back(S_BRANCH);
    end else if (o == 2'b00 && mulpat && en) begin
      ismul = 1;
      repeat (mc) seq.push_back(S_MULEXEC);
      seq.push_back(S_ALUWB);
    end else if (o == 2'b00 && !mulpat && cmd_legal(f[4:1])) begin
      nw = (f[4:1] == 4'b1010);
      seq.push_back(f[5] ? S_EXECI : S_EXECR);
      seq.push_back(S_ALUWB);
    end else begin
      ill = 1;
    end
    op_i[k] = o; fn_i[k] = f; rd_i[k] = d; i74_i[k] = i7;
    tag = inum[k] * 16;
    ab  = (abort_at < int'(seq.size())) ? abort_at : -1;
    if (ab < 0) begin
      foreach (seq[i]) push(k, model_out(seq[i], o, f, d, nw, ismul, ill, 1'b0), tag + i);
      repeat (seq.size()) @(posedge clk);
      #1;
    end else begin
      for (int i = 0; i < ab; i++) push(k, model_out(seq[i], o, f, d, nw, ismul, ill, 1'b0), tag + i);
      if (ab > 0) begin
        repeat (ab) @(posedge clk);
        #1;
      end
      rst_n[k] = 1'b0;
      push(k, model_out(seq[ab], o, f, d, nw, ismul, ill, 1'b1), tag + ab);
      @(posedge clk); #1;
      push(k, model_out(S_FETCH, o, f, d, nw, ismul, ill, 1'b1), tag + ab + 1);
      @(posedge clk); #1;
      rst_n[k] = 1'b1;
    end
    inum[k]++;
  endtask

  task automatic run(input int k);
    issue(k, 2'b00, 6'b001001, 4'd3,  4'd0,    -1); // ADDS
    issue(k, 2'b00, 6'b010101, 4'hF,  4'd0,    -1); // CMP to Rd=15
    issue(k, 2'b00, 6'b000001, 4'hF,  4'b1001, -1); // MULS
    issue(k, 2'b01, 6'b011001, 4'hF,  4'd0,    -1); // LDR to PC
    issue(k, 2'b01, 6'b011000, 4'd2,  4'd0,    -1); // STR
    issue(k, 2'b10, 6'b101000, 4'd0,  4'd0,    -1); // B
    issue(k, 2'b00, 6'b000000, 4'd5,  4'b1001,  3); // MUL, reset in 2nd MULEXEC
    issue(k, 2'b00, 6'b001000, 4'd5,  4'd0,     3); // ADD, reset in ALUWB
    issue(k, 2'b00, 6'b001110, 4'd1,  4'd0,    -1); // unknown cmd 0111
    issue(k, 2'b00, 6'b100011, 4'hF,  4'd0,    -1); // EORS immediate
    issue(k, 2'b00, 6'b111010, 4'd7,  4'd0,    -1); // MOV immediate
    issue(k, 2'b11, 6'b000000, 4'd0,  4'd0,    -1); // unsupported op
    for (int n = 0; n < 60; n++) begin
      logic [1:0] o;
      logic [5:0] f;
      logic [3:0] d, i7;
      int sel, ab;
      sel = int'($urandom_range(0, 9));
      f   = 6'($urandom);
      i7  = 4'($urandom);
      d   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      o   = 2'b00;
      case (sel)
        5, 6: o = 2'b01;
        7:    o = 2'b10;
        8:    o = 2'b11;
        9:    begin f[5:4] = 2'b00; i7 = 4'b1001; end
        default: ;
      endcase
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      issue(k, o, f, d, i7, ab);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      rec_t e;
      int   t;
      e = q0.pop_front();
      t = t0.pop_front();
      total++;
      if (act0 !== e) begin
        bad++;
        $display("FAIL dut0 instr%0d cyc%0d got=%h exp=%h", t / 16, t % 16, act0, e);
      end
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      rec_t e;
      int   t;
      e = q1.pop_front();
      t = t1.pop_front();
      total++;
      if (act1 !== e) begin
        bad++;
        $display("FAIL dut1 instr%0d cyc%0d got=%h exp=%h", t / 16, t % 16, act1, e);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; op_i[k] = 2'b00; fn_i[k] = 6'd0; rd_i[k] = 4'd0; i74_i[k] = 4'd0;
      inum[k] = 0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      repeat (3) push(k, model_out(S_FETCH, 2'b00, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      run(0);
      run(1);
    join
    repeat (3) @(negedge clk);
    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL drain0 got=%0d pending required=0", q0.size());
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL drain1 got=%0d pending required=0", q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
